// File: rtl/subcore_dispatcher.sv
// subcore_dispatcher: hands parallel-task launches from the main core to idle
// subcores in round-robin order, tracks per-core busy state from end pulses,
// and provides a join barrier that completes once every subcore is idle.

// Per-core slot: busy flag, one-cycle exec pulse, and the held PC/arguments.
module subcore_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        launch_i,
    input  logic        end_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] u_i,
    input  logic [31:0] l_i,
    output logic        busy_o,
    output logic        exec_o,
    output logic [31:0] pc_o,
    output logic [31:0] u_o,
    output logic [31:0] l_o,
    output logic        end_ok_o,
    output logic        end_bad_o
);
    logic        busy_q, busy_d;
    logic        exec_q, exec_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] u_q, u_d;
    logic [31:0] l_q, l_d;

    // An end counts only for a busy core past its issue cycle; anything else is spurious.
    assign end_ok_o  = end_i & busy_q & ~exec_q;
    assign end_bad_o = end_i & ~(busy_q & ~exec_q);

    // Next-state: launch sets busy and latches arguments, a valid end clears busy.
    always_comb begin
        busy_d = busy_q;
        exec_d = launch_i;
        pc_d   = pc_q;
        u_d    = u_q;
        l_d    = l_q;
        if (end_ok_o) busy_d = 1'b0;
        if (launch_i) begin
            busy_d = 1'b1;
            pc_d   = pc_i;
            u_d    = u_i;
            l_d    = l_i;
        end
    end

    // Slot registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            exec_q <= 1'b0;
            pc_q   <= '0;
            u_q    <= '0;
            l_q    <= '0;
        end else begin
            busy_q <= busy_d;
            exec_q <= exec_d;
            pc_q   <= pc_d;
            u_q    <= u_d;
            l_q    <= l_d;
        end
    end

    assign busy_o = busy_q;
    assign exec_o = exec_q;
    assign pc_o   = pc_q;
    assign u_o    = u_q;
    assign l_o    = l_q;
endmodule

module subcore_dispatcher #(
    parameter int SUBCORE_NUM = 4,
    parameter int ID_W        = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_pc,
    input  logic [31:0]              req_u,
    input  logic [31:0]              req_l,
    output logic [ID_W-1:0]          req_core,
    input  logic                     join_valid,
    output logic                     join_done,
    output logic [SUBCORE_NUM-1:0]   exec_requested,
    output logic [32*SUBCORE_NUM-1:0] requested_pc,
    output logic [32*SUBCORE_NUM-1:0] u_n_in,
    output logic [32*SUBCORE_NUM-1:0] l_n_in,
    input  logic [SUBCORE_NUM-1:0]   subcore_ended,
    output logic [SUBCORE_NUM-1:0]   busy_mask,
    output logic [31:0]              completed_cnt,
    output logic                     err_spurious
);
    typedef enum logic {RUN, JOIN_WAIT} state_t;

    state_t                        state_q, state_d;
    logic [ID_W-1:0]               rr_q, rr_d;
    logic [31:0]                   cnt_q, cnt_d;
    logic                          err_q, err_d;
    logic [SUBCORE_NUM-1:0]        busy, exec, end_ok, end_bad, launch_vec;
    logic [SUBCORE_NUM-1:0][31:0]  pc_arr, u_arr, l_arr;
    logic [ID_W-1:0]               sel;
    logic                          handshake;

    // Readiness depends only on registered state, so a core freed this cycle waits a cycle.
    assign req_ready = (state_q == RUN) && (busy != '1);
    assign handshake = req_valid && req_ready;
    assign req_core  = sel;

    // Round-robin pick: first idle core scanning from rr_q upward, wrapping.
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < SUBCORE_NUM; k++) begin
            idx = (int'(rr_q) + k) % SUBCORE_NUM;
            if (!found && !busy[ID_W'(idx)]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
    end

    // One-hot launch strobe to the selected slot.
    always_comb begin
        launch_vec = '0;
        if (handshake) launch_vec[sel] = 1'b1;
    end

    for (genvar i = 0; i < SUBCORE_NUM; i++) begin : g_slot
        subcore_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .launch_i (launch_vec[i]),
            .end_i    (subcore_ended[i]),
            .pc_i     (req_pc),
            .u_i      (req_u),
            .l_i      (req_l),
            .busy_o   (busy[i]),
            .exec_o   (exec[i]),
            .pc_o     (pc_arr[i]),
            .u_o      (u_arr[i]),
            .l_o      (l_arr[i]),
            .end_ok_o (end_ok[i]),
            .end_bad_o(end_bad[i])
        );
    end

    // Barrier release: all cores idle and nothing retiring this cycle.
    assign join_done = (state_q == JOIN_WAIT) && (busy == '0) && (end_ok == '0);

    // Completion counter, sticky error and round-robin pointer.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < SUBCORE_NUM; i++) cnt_d = cnt_d + 32'(end_ok[i]);
        err_d = err_q | (|end_bad);
        rr_d  = rr_q;
        if (handshake) rr_d = ID_W'((int'(sel) + 1) % SUBCORE_NUM);
    end

    // FSM next state: a launch in the same cycle defers the join by a cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:       if (join_valid && !handshake) state_d = JOIN_WAIT;
            JOIN_WAIT: if (join_done) state_d = RUN;
            default:   state_d = RUN;
        endcase
    end

    // Control registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            rr_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign exec_requested = exec;
    assign requested_pc   = pc_arr;
    assign u_n_in         = u_arr;
    assign l_n_in         = l_arr;
    assign busy_mask      = busy;
    assign completed_cnt  = cnt_q;
    assign err_spurious   = err_q;
endmodule
